instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the instruction decode controller. Accepts abstract micro-ops (the same 5-bit alu_code space
//  the decoder emits, plus register/immediate fields) over a valid/ready handshake, packs them into 32-bit MIPS
//  words, buffers them in a FIFO and streams them into instruction memory at consecutive addresses.
//  Used as the program loader/self-test generator feeding IMEM ahead of the datapath.
// PARAMETERS
//  ADDR_W     8  IMEM word-address width; capacity = 2**ADDR_W words
//  FIFO_DEPTH 4  encoded-word buffer entries (power of 2, >=2)
//  BASE_ADDR  0  first IMEM word address written after reset/clear
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       synchronous active-low reset
//  clear      in   1       sync soft restart: empty FIFO, address back to BASE_ADDR
//  in_valid   in   1       micro-op present
//  in_ready   out  1       encoder can accept micro-op this cycle
//  in_code    in   5       operation code (table below)
//  in_rs/in_rt/in_rd in 5  register fields
//  in_shamt   in   5       shift amount
//  in_imm     in   16      immediate
//  in_target  in   26      jump target field
//  imem_wen   out  1       write request to IMEM
//  imem_ready in   1       IMEM accepts write this cycle
//  imem_addr  out  ADDR_W  write word address
//  imem_wdata out  32      encoded instruction
//  err_code   out  1       1-cycle pulse: accepted micro-op had illegal code
//  words_done out  ADDR_W+1 count of words written to IMEM since reset/clear
// BEHAVIOUR
//  Code table (op/funct hex): 0 add f20,1 addu f21,2 sub f22,3 subu f23,4 and f24,5 or f25,6 nor f27,
//   7 slt f2A,8 sll f00,9 srl f02,10 sra f03,11 jr f08,12 nop (32'h0),13 andi o0C,14 ori o0D,15 slti o0A,
//   16 addi o08,17 addiu o09,18 lw o23,19 sw o2B,20 lui o0F,21 j o02,22 jal o03; 23..31 illegal.
//  R-type {6'h00,rs,rt,rd,shamt,funct}; shamt forced 0 except 8-10; rs forced 0 for 8-10;
//   rt,rd,shamt forced 0 for jr. I-type {op,rs,rt,imm}; rs forced 0 for lui. J-type {op,target}.
//  Accept on rising edge with in_valid&in_ready; encoding combinational, pushed into FIFO same edge.
//  in_ready = !fifo_full && !clear && (accepted_cnt < 2**ADDR_W); accepted_cnt counts legal pushes.
//  Illegal code: accepted (handshake completes), nothing pushed, err_code=1 next cycle only.
//  Output: imem_wen = FIFO non-empty; imem_addr/imem_wdata driven from FIFO head/address counter,
//   held stable while imem_wen&!imem_ready. Pop, addr++ and words_done++ on edge with imem_wen&imem_ready.
//  Latency: word accepted at edge N appears with imem_wen=1 after edge N (earliest write edge N+1); no bypass.
//  Throughput: 1 word/cycle sustained when imem_ready held high.
//  Full FIFO: in_ready=0; push and pop in same cycle allowed whenever not full.
//  Capacity: after 2**ADDR_W legal accepts in_ready stays 0 until reset/clear; no word dropped, address never
//   wraps past BASE_ADDR+2**ADDR_W-1 (mod 2**ADDR_W addressing, BASE_ADDR offset wraps naturally).
//  clear and rst_n identical in effect; rst_n dominates; both abort any pending write (IMEM not written that edge).
//  Reset values: in_ready=0 during reset then 1, imem_wen=0, imem_addr=BASE_ADDR, imem_wdata=0,
//   err_code=0, words_done=0.
// STRUCTURE
//  Shared package mips_pkg: alu_code localparams (shared with decode controller), opcode and funct constants,
//   encode_instr() function mapping code+fields to 32-bit word.
//  One sub-module: sync_fifo (WIDTH=32, DEPTH=FIFO_DEPTH, sync active-low reset, flush input).
//  Top: accept control, capacity counter, address counter, err pulse register.
// TESTING
//  code0 rs1 rt2 rd3 -> imem_wdata 32'h00221820 @ BASE_ADDR, imem_wen one edge after accept.
//  code16 rs1 rt2 imm5 -> 32'h20220005; code8 rt2 rd3 shamt4 (rs=7 junk) -> 32'h00021900.
//  code18 rs29 rt8 imm4 -> 32'h8FA80004; code21 target 0x10 -> 32'h08000010; addresses +1 each.
//  imem_ready=0 for 10 cycles, 6 pushes -> in_ready drops after 4, data/addr held; release -> 4 words in order.
//  code25 -> err_code pulse 1 cycle, no write, words_done unchanged; ADDR_W=2: 5th legal push refused.
//  clear and rst_n asserted mid-stream with FIFO 3 deep -> imem_wen=0 next cycle, next write at BASE_ADDR.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and the micro-op to instruction-word packer.
package mips_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0,  ALU_ADDU  = 5'd1,  ALU_SUB  = 5'd2,  ALU_SUBU = 5'd3;
  localparam logic [4:0] ALU_AND  = 5'd4,  ALU_OR    = 5'd5,  ALU_NOR  = 5'd6,  ALU_SLT  = 5'd7;
  localparam logic [4:0] ALU_SLL  = 5'd8,  ALU_SRL   = 5'd9,  ALU_SRA  = 5'd10, ALU_JR   = 5'd11;
  localparam logic [4:0] ALU_NOP  = 5'd12, ALU_ANDI  = 5'd13, ALU_ORI  = 5'd14, ALU_SLTI = 5'd15;
  localparam logic [4:0] ALU_ADDI = 5'd16, ALU_ADDIU = 5'd17, ALU_LW   = 5'd18, ALU_SW   = 5'd19;
  localparam logic [4:0] ALU_LUI  = 5'd20, ALU_J     = 5'd21, ALU_JAL  = 5'd22;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24, FN_OR  = 6'h25, FN_NOR = 6'h27, FN_SLT = 6'h2A;

  function automatic logic code_is_legal(input logic [4:0] code);
    return code <= ALU_JAL;
  endfunction

  // Fields that the target format does not use are forced to zero so the word is canonical.
  function automatic logic [31:0] encode_instr(input logic [4:0] code, input logic [4:0] rs,
                                               input logic [4:0] rt, input logic [4:0] rd,
                                               input logic [4:0] shamt, input logic [15:0] imm,
                                               input logic [25:0] target);
    logic [31:0] w;
    w = '0;
    case (code)
      ALU_ADD:   w = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
      ALU_ADDU:  w = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADDU};
      ALU_SUB:   w = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
      ALU_SUBU:  w = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUBU};
      ALU_AND:   w = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
      ALU_OR:    w = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
      ALU_NOR:   w = {OP_RTYPE, rs, rt, rd, 5'd0, FN_NOR};
      ALU_SLT:   w = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
      ALU_SLL:   w = {OP_RTYPE, 5'd0, rt, rd, shamt, FN_SLL};
      ALU_SRL:   w = {OP_RTYPE, 5'd0, rt, rd, shamt, FN_SRL};
      ALU_SRA:   w = {OP_RTYPE, 5'd0, rt, rd, shamt, FN_SRA};
      ALU_JR:    w = {OP_RTYPE, rs, 15'd0, FN_JR};
      ALU_NOP:   w = '0;
      ALU_ANDI:  w = {OP_ANDI, rs, rt, imm};
      ALU_ORI:   w = {OP_ORI, rs, rt, imm};
      ALU_SLTI:  w = {OP_SLTI, rs, rt, imm};
      ALU_ADDI:  w = {OP_ADDI, rs, rt, imm};
      ALU_ADDIU: w = {OP_ADDIU, rs, rt, imm};
      ALU_LW:    w = {OP_LW, rs, rt, imm};
      ALU_SW:    w = {OP_SW, rs, rt, imm};
      ALU_LUI:   w = {OP_LUI, 5'd0, rt, imm};
      ALU_J:     w = {OP_J, target};
      ALU_JAL:   w = {OP_JAL, target};
      default:   w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with active-low reset and a synchronous flush; head is shown combinationally.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign full   = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
    end
  end
endmodule

// File: rtl/instr_encoder.sv
// Packs micro-ops into MIPS words, buffers them and streams them into IMEM at consecutive addresses.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_code,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_wen,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err_code,
  output logic [ADDR_W:0]   words_done
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CAP  = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W:0]   r_accepted;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_words;
  logic              r_err;
  logic              w_full;
  logic              w_empty;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_legal;
  logic              w_push;
  logic              w_wen;
  logic              w_write;
  logic [31:0]       w_enc;
  logic [31:0]       w_head;

  assign w_in_ready = rst_n && !clear && !w_full && (r_accepted < CAP);
  assign w_accept   = in_valid && w_in_ready;
  assign w_legal    = code_is_legal(in_code);
  assign w_push     = w_accept && w_legal;
  assign w_enc      = encode_instr(in_code, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);

  // Reset and clear mask the write strobe so a pending word never lands on the abort edge.
  assign w_wen      = !w_empty && rst_n && !clear;
  assign w_write    = w_wen && imem_ready;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clear),
    .push  (w_push),
    .din   (w_enc),
    .pop   (w_write),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_accepted <= '0;
      r_addr     <= BASE;
      r_words    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_push) r_accepted <= r_accepted + (ADDR_W+1)'(1);
      if (w_write) begin
        r_addr  <= r_addr + ADDR_W'(1);
        r_words <= r_words + (ADDR_W+1)'(1);
      end
      r_err <= w_accept && !w_legal;
    end
  end

  assign in_ready   = w_in_ready;
  assign imem_wen   = w_wen;
  assign imem_addr  = r_addr;
  assign imem_wdata = w_wen ? w_head : '0;
  assign err_code   = r_err;
  assign words_done = r_words;
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a main instance plus a tiny-address instance for capacity limits.
module tb_instr_encoder;
  localparam int unsigned AW = 8, BASE = 5, SAW = 2, SBASE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clear, in_valid, imem_ready, in_ready, imem_wen, err_code;
  logic [4:0]    in_code, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   words_done;

  logic           s_rst_n, s_clear, s_valid, s_imem_ready, s_in_ready, s_wen, s_err;
  logic [4:0]     s_code;
  logic [SAW-1:0] s_addr;
  logic [31:0]    s_wdata;
  logic [SAW:0]   s_done;

  instr_encoder #(.ADDR_W(AW), .FIFO_DEPTH(4), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .imem_wen(imem_wen), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .err_code(err_code), .words_done(words_done));

  instr_encoder #(.ADDR_W(SAW), .FIFO_DEPTH(4), .BASE_ADDR(SBASE)) dut_small (
    .clk(clk), .rst_n(s_rst_n), .clear(s_clear), .in_valid(s_valid), .in_ready(s_in_ready),
    .in_code(s_code), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .imem_wen(s_wen), .imem_ready(s_imem_ready),
    .imem_addr(s_addr), .imem_wdata(s_wdata), .err_code(s_err), .words_done(s_done));

  typedef struct packed { logic [AW-1:0] addr; logic [31:0] data; } exp_t;

  exp_t           q[$];
  logic [SAW+31:0] sq[$];
  logic [AW-1:0]  exp_addr;
  logic [AW:0]    exp_words;
  int             n_cmp = 0;
  int             n_err = 0;
  int             cyc = 0;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] ref_enc(input int c, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [15:0] imm, input logic [25:0] tg);
    logic [5:0] f, o;
    f = 6'h00; o = 6'h00;
    case (c)
      0: f = 6'h20; 1: f = 6'h21; 2: f = 6'h22; 3: f = 6'h23;
      4: f = 6'h24; 5: f = 6'h25; 6: f = 6'h27; 7: f = 6'h2A;
      8: f = 6'h00; 9: f = 6'h02; 10: f = 6'h03; 11: f = 6'h08;
      13: o = 6'h0C; 14: o = 6'h0D; 15: o = 6'h0A; 16: o = 6'h08; 17: o = 6'h09;
      18: o = 6'h23; 19: o = 6'h2B; 20: o = 6'h0F; 21: o = 6'h02; 22: o = 6'h03;
      default: ;
    endcase
    if (c <= 7)  return {6'h00, rs, rt, rd, 5'h00, f};
    if (c <= 10) return {11'h000, rt, rd, sh, f};
    if (c == 11) return {6'h00, rs, 15'h0000, f};
    if (c == 12) return 32'h0;
    if (c == 20) return {o, 5'h00, rt, imm};
    if (c <= 19) return {o, rs, rt, imm};
    return {o, tg};
  endfunction

  // Scoreboard: each IMEM write seen at the negedge before its write edge pops one expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (imem_wen && imem_ready) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL imem_write: got addr=%h data=%h, expected no write", imem_addr, imem_wdata);
      end else begin
        e = q.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data) begin
          n_err++;
          $display("FAIL imem_write: got addr=%h data=%h, expected addr=%h data=%h",
                   imem_addr, imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  always @(negedge clk) begin : smon
    logic [SAW+31:0] e;
    if (s_wen && s_imem_ready) begin
      n_cmp++;
      if (sq.size() == 0) begin
        n_err++;
        $display("FAIL small_write: got addr=%h data=%h, expected no write", s_addr, s_wdata);
      end else begin
        e = sq.pop_front();
        if ({s_addr, s_wdata} !== e) begin
          n_err++;
          $display("FAIL small_write: got %h expected %h", {s_addr, s_wdata}, e);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int c, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] tg);
    int unsigned waited;
    waited = 0;
    in_code = 5'(c); in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm; in_target = tg;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL accept_timeout: in_ready=%b, expected 1 within 40 cycles", in_ready);
    end else if (c <= 22) begin
      q.push_back({exp_addr, ref_enc(c, rs, rt, rd, sh, imm, tg)});
      exp_addr++;
      exp_words++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain_and_check(input string name);
    int unsigned n;
    imem_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0 || words_done !== exp_words) begin
      n_err++;
      $display("FAIL %s_drain: pending=%0d words_done=%0d, expected pending=0 words_done=%0d",
               name, q.size(), words_done, exp_words);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; imem_ready = 1'b0;
    s_rst_n = 1'b0; s_clear = 1'b0; s_valid = 1'b0; s_imem_ready = 1'b1; s_code = '0;
    in_code = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0; in_target = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({in_ready, imem_wen, err_code} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got ready/wen/err=%b, expected 000", {in_ready, imem_wen, err_code});
    end
    n_cmp++;
    if (imem_addr !== AW'(BASE) || imem_wdata !== 32'h0 || words_done !== '0) begin
      n_err++;
      $display("FAIL reset_values: got addr=%h wdata=%h done=%0d, expected addr=%h wdata=0 done=0",
               imem_addr, imem_wdata, words_done, AW'(BASE));
    end
    @(posedge clk); #1;
    rst_n = 1'b1; s_rst_n = 1'b1;
    exp_addr = AW'(BASE); exp_words = '0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || imem_wen !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got ready=%b wen=%b, expected ready=1 wen=0", in_ready, imem_wen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_encode;
    int          vc[5] = '{0, 16, 8, 18, 21};
    logic [4:0]  vrs[5] = '{5'd1, 5'd1, 5'd7, 5'd29, 5'd0};
    logic [4:0]  vrt[5] = '{5'd2, 5'd2, 5'd2, 5'd8, 5'd0};
    logic [4:0]  vrd[5] = '{5'd3, 5'd0, 5'd3, 5'd0, 5'd0};
    logic [4:0]  vsh[5] = '{5'd0, 5'd0, 5'd4, 5'd0, 5'd0};
    logic [15:0] vim[5] = '{16'h0, 16'h5, 16'h0, 16'h4, 16'h0};
    logic [25:0] vtg[5] = '{26'h0, 26'h0, 26'h0, 26'h0, 26'h10};
    logic [31:0] vex[5] = '{32'h00221820, 32'h20220005, 32'h00021900, 32'h8FA80004, 32'h08000010};
    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(vc[i], vrs[i], vrt[i], vrd[i], vsh[i], vim[i], vtg[i]);
      @(negedge clk);
      n_cmp++;
      if (imem_wen !== 1'b1 || imem_addr !== AW'(BASE + i) || imem_wdata !== vex[i]) begin
        n_err++;
        $display("FAIL encode_%0d: got wen=%b addr=%h data=%h, expected wen=1 addr=%h data=%h",
                 i, imem_wen, imem_addr, imem_wdata, AW'(BASE + i), vex[i]);
      end
      @(posedge clk); #1;
      imem_ready = 1'b1;
      @(posedge clk); #1;
      imem_ready = 1'b0;
    end
    drain_and_check("encode");
  endtask

  task automatic test_back_to_back;
    int t0;
    imem_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 8; i++)
      send($urandom_range(0, 22), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           16'($urandom), 26'($urandom));
    n_cmp++;
    if (cyc - t0 != 8) begin
      n_err++;
      $display("FAIL back_to_back_cycles: got %0d cycles, expected 8", cyc - t0);
    end
    drain_and_check("back_to_back");
  endtask

  task automatic test_stall;
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(13 + i, 5'(i), 5'(i + 1), 5'd0, 5'd0, 16'(16'h100 + i), 26'd0);
    in_code = 5'd0; in_rs = 5'd4; in_rt = 5'd5; in_rd = 5'd6; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0 || imem_wen !== 1'b1 || imem_addr !== q[0].addr || imem_wdata !== q[0].data) begin
        n_err++;
        $display("FAIL stall_hold_%0d: got ready=%b wen=%b addr=%h data=%h, expected ready=0 wen=1 addr=%h data=%h",
                 i, in_ready, imem_wen, imem_addr, imem_wdata, q[0].addr, q[0].data);
      end
      @(posedge clk); #1;
    end
    imem_ready = 1'b1;
    send(0, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0, 26'd0);
    send(9, 5'd0, 5'd5, 5'd6, 5'd31, 16'd0, 26'd0);
    drain_and_check("stall");
  endtask

  task automatic test_error;
    imem_ready = 1'b1;
    send(25, 5'd1, 5'd2, 5'd3, 5'd4, 16'hFFFF, 26'h3FFFFFF);
    @(negedge clk);
    n_cmp++;
    if (err_code !== 1'b1 || imem_wen !== 1'b0) begin
      n_err++;
      $display("FAIL err_pulse: got err=%b wen=%b, expected err=1 wen=0", err_code, imem_wen);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (err_code !== 1'b0 || words_done !== exp_words) begin
      n_err++;
      $display("FAIL err_end: got err=%b done=%0d, expected err=0 done=%0d", err_code, words_done, exp_words);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort(input bit use_reset);
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1 + i, 5'd9, 5'd10, 5'd11, 5'd0, 16'd0, 26'd0);
    imem_ready = 1'b1;
    if (use_reset) rst_n = 1'b0; else clear = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (imem_wen !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL abort_%0d_during: got wen=%b ready=%b, expected 0 0", use_reset, imem_wen, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; clear = 1'b0;
    q.delete();
    exp_addr = AW'(BASE); exp_words = '0;
    @(negedge clk);
    n_cmp++;
    if (imem_wen !== 1'b0 || imem_addr !== AW'(BASE) || words_done !== '0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_%0d_after: got wen=%b addr=%h done=%0d ready=%b, expected 0 %h 0 1",
               use_reset, imem_wen, imem_addr, words_done, in_ready, AW'(BASE));
    end
    @(posedge clk); #1;
    send(20, 5'd31, 5'd7, 5'd0, 5'd0, 16'hBEEF, 26'd0);
    drain_and_check(use_reset ? "abort_rst" : "abort_clr");
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      imem_ready = (q.size() >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
      send($urandom_range(0, 31), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           16'($urandom), 26'($urandom));
    end
    drain_and_check("random");
  endtask

  task automatic test_capacity;
    logic [SAW-1:0] sa;
    int             c;
    int unsigned    n;
    sa = SAW'(SBASE);
    s_imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c = $urandom_range(13, 22);
      s_code = 5'(c); in_rs = 5'($urandom); in_rt = 5'($urandom); in_imm = 16'($urandom);
      in_target = 26'($urandom); s_valid = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (s_in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL cap_accept_%0d: got in_ready=%b expected 1", i, s_in_ready);
      end else begin
        sq.push_back({sa, ref_enc(c, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target)});
        sa++;
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (s_in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL cap_refuse_%0d: got in_ready=%b expected 0", i, s_in_ready);
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    n = 0;
    while (sq.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
    n_cmp++;
    if (sq.size() != 0 || s_done !== 3'd4 || s_wen !== 1'b0) begin
      n_err++;
      $display("FAIL cap_done: pending=%0d done=%0d wen=%b, expected pending=0 done=4 wen=0",
               sq.size(), s_done, s_wen);
    end
    @(posedge clk); #1;
    s_clear = 1'b1;
    @(posedge clk); #1;
    s_clear = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (s_in_ready !== 1'b1 || s_addr !== SAW'(SBASE) || s_done !== '0) begin
      n_err++;
      $display("FAIL cap_clear: got ready=%b addr=%h done=%0d, expected 1 %h 0", s_in_ready, s_addr, s_done,
               SAW'(SBASE));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_encode();
    test_back_to_back();
    test_stall();
    test_error();
    test_abort(1'b0);
    test_abort(1'b1);
    test_random();
    test_capacity();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
